// File: rtl/somador_pkg.sv
// Shared definitions for the nibble-serial adder controller: nibble width,
// FSM state encoding and the index-width helper.
package somador_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADD  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Width of a counter that indexes n nibbles; never narrower than one bit
   function automatic int clog2(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/somador4b.sv
// Combinational 4-bit ripple adder shared by the sequencing controller.
module somador4b
   import somador_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] s,
   output logic                cout
);

   logic [NIBBLE_W:0] full;

   // One addition of the two nibbles plus incoming carry
   always_comb begin
      full = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
   end

   assign s    = full[NIBBLE_W-1:0];
   assign cout = full[NIBBLE_W];

endmodule

// File: rtl/somador_seq_ctrl.sv
// Wide adder built by time-multiplexing one 4-bit adder, LSB nibble first,
// with the carry chained through a register between nibbles.
//
// Handshake: the requester raises start; the request is taken on a rising
// edge where ready=1, and a/b/cin are sampled on that edge only. busy is
// high while nibbles are being added, and done pulses for exactly one cycle
// when s/cout/ovf hold the new result. start outside IDLE is ignored.
module somador_seq_ctrl
   import somador_pkg::*;
#(
   parameter  int NIBBLES = 4,
   localparam int W       = NIBBLE_W * NIBBLES
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic         ready,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] s,
   output logic         cout,
   output logic         ovf,
   output logic [1:0]   state_dbg
);

   localparam int            IW   = clog2(NIBBLES);
   localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

   state_t                           state;
   logic [IW-1:0]                    idx;
   logic                             carry;
   logic [NIBBLES-1:0][NIBBLE_W-1:0] op_a;
   logic [NIBBLES-1:0][NIBBLE_W-1:0] op_b;
   logic [NIBBLES-1:0][NIBBLE_W-1:0] work;
   logic [NIBBLES-1:0][NIBBLE_W-1:0] result;

   logic [NIBBLE_W-1:0] nib_a;
   logic [NIBBLE_W-1:0] nib_b;
   logic [NIBBLE_W-1:0] nib_s;
   logic                nib_c;
   logic                ovf_next;

   assign state_dbg = state;

   // Nibble-select muxes feeding the shared adder
   assign nib_a = op_a[idx];
   assign nib_b = op_b[idx];

   somador4b u_add (
      .a    (nib_a),
      .b    (nib_b),
      .cin  (carry),
      .s    (nib_s),
      .cout (nib_c)
   );

   // Full result as it will look once the current nibble is written back;
   // used on the final edge so s never shows a partial sum
   always_comb begin
      result      = work;
      result[idx] = nib_s;
      ovf_next    = (op_a[NIBBLES-1][NIBBLE_W-1] == op_b[NIBBLES-1][NIBBLE_W-1]) &&
                    (result[NIBBLES-1][NIBBLE_W-1] != op_a[NIBBLES-1][NIBBLE_W-1]);
   end

   // Control FSM with registered handshake and result outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         ready <= 1'b1;
         busy  <= 1'b0;
         done  <= 1'b0;
         s     <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
         idx   <= '0;
         carry <= 1'b0;
         op_a  <= '0;
         op_b  <= '0;
         work  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  op_a  <= a;
                  op_b  <= b;
                  carry <= cin;
                  idx   <= '0;
                  ready <= 1'b0;
                  busy  <= 1'b1;
                  state <= ST_ADD;
               end
            end
            ST_ADD: begin
               work[idx] <= nib_s;
               carry     <= nib_c;
               if (idx == LAST) begin
                  s     <= result;
                  cout  <= nib_c;
                  ovf   <= ovf_next;
                  idx   <= '0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= ST_DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               ready <= 1'b1;
               state <= ST_IDLE;
            end
            default: begin
               ready <= 1'b1;
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
